// File: rtl/wave_capture_ctrl.sv
// ---------------------------------------------------------------------------
// wave_capture_ctrl
//
// Controls capture into a double-buffered 512-entry sample RAM for the
// waveform display. The controller waits for a rising zero crossing in the
// audio stream. It then writes 256 consecutive samples into the half of the
// RAM that the display is not reading. When the display next reports idle,
// the controller hands that half over by toggling read_index. The display
// therefore always scans a complete, triggered and stable capture.
//
// If no crossing arrives within TIMEOUT accepted samples, the controller
// forces a trigger on the current sample. forced_trigger flags such a
// capture. TIMEOUT = 0 disables the forced trigger.
//
// Ports
//   clk               in   1         system clock
//   reset             in   1         asynchronous, active-low reset
//   new_sample_ready  in   1         sample strobe; only its rising edge counts
//   new_sample_in     in   SAMPLE_W  signed sample, valid while strobe is high
//   wave_display_idle in   1         display is not reading the RAM
//   write_address     out  9         {capture half, index within capture}
//   write_enable      out  1         one-cycle RAM write strobe
//   write_sample      out  8         offset-binary top 8 bits of the sample
//   read_index        out  1         RAM half the display reads
//   forced_trigger    out  1         current capture was started by timeout
// ---------------------------------------------------------------------------
module wave_capture_ctrl #(
   parameter int SAMPLE_W = 16,
   parameter int TIMEOUT  = 2048
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       new_sample_ready,
   input  logic signed [SAMPLE_W-1:0] new_sample_in,
   input  logic                       wave_display_idle,
   output logic [8:0]                 write_address,
   output logic                       write_enable,
   output logic [7:0]                 write_sample,
   output logic                       read_index,
   output logic                       forced_trigger
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               ready_p1;
   logic               prev_neg;
   logic [7:0]         idx;
   logic [CNT_W-1:0]   timeout_cnt;

   logic               accept;
   logic               sign;
   logic               crossing;
   logic               timeout_hit;
   logic               do_write;
   logic               trig_cross;
   logic               trig_force;
   logic               cnt_inc;
   logic               flip;
   logic [7:0]         wr_idx;

   // The display stores only the top 8 bits. The lower bits fall below its
   // resolution and are dropped on purpose.
   logic               unused_low_bits;
   assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];

   // Converts the top 8 bits of a two's complement sample to offset binary.
   function automatic logic [7:0] to_offset_binary(input logic [7:0] top);
      return {~top[7], top[6:0]};
   endfunction

   // A held strobe yields one sample. The strobe must go low before the next
   // sample can be accepted.
   assign accept   = new_sample_ready & ~ready_p1;
   assign sign     = new_sample_in[SAMPLE_W-1];
   assign crossing = prev_neg & ~sign;
   assign timeout_hit = (TIMEOUT != 0) && (timeout_cnt == CNT_W'(TIMEOUT - 1));

   // ---- next state / capture decisions ----
   always_comb begin
      state_next = state;
      do_write   = 1'b0;
      trig_cross = 1'b0;
      trig_force = 1'b0;
      cnt_inc    = 1'b0;
      flip       = 1'b0;
      wr_idx     = idx;
      case (state)
         ARMED: begin
            wr_idx = 8'd0;
            if (accept) begin
               if (crossing) begin
                  do_write   = 1'b1;
                  trig_cross = 1'b1;
                  state_next = ACTIVE;
               end else if (timeout_hit) begin
                  do_write   = 1'b1;
                  trig_force = 1'b1;
                  state_next = ACTIVE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (accept) begin
               do_write = 1'b1;
               if (idx == 8'hFF) state_next = WAIT;
            end
         end
         WAIT: begin
            if (wave_display_idle) begin
               flip       = 1'b1;
               state_next = ARMED;
            end
         end
         default: state_next = ARMED;
      endcase
   end

   // ---- state register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ARMED;
      else        state <= state_next;
   end

   // ---- capture bookkeeping and registered RAM write port ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_p1       <= 1'b0;
         prev_neg       <= 1'b0;
         idx            <= 8'd0;
         timeout_cnt    <= '0;
         read_index     <= 1'b0;
         forced_trigger <= 1'b0;
         write_enable   <= 1'b0;
         write_address  <= 9'd0;
         write_sample   <= 8'd0;
      end else begin
         ready_p1     <= new_sample_ready;
         write_enable <= do_write;
         if (accept) prev_neg <= sign;
         if (do_write) begin
            // Wraps to 0 after index 255, so the next capture starts at 0.
            idx           <= wr_idx + 8'd1;
            write_address <= {~read_index, wr_idx};
            write_sample  <= to_offset_binary(new_sample_in[SAMPLE_W-1 -: 8]);
         end
         if (trig_cross || trig_force) timeout_cnt <= '0;
         else if (cnt_inc)             timeout_cnt <= timeout_cnt + CNT_W'(1);
         if (trig_force)      forced_trigger <= 1'b1;
         else if (trig_cross) forced_trigger <= 1'b0;
         if (flip) read_index <= ~read_index;
      end
   end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
module tb_wave_capture_ctrl;

   logic               clk = 1'b0;
   logic               reset;
   logic               new_sample_ready;
   logic signed [15:0] new_sample_in;
   logic               wave_display_idle;
   logic [8:0]         write_address;
   logic               write_enable;
   logic [7:0]         write_sample;
   logic               read_index;
   logic               forced_trigger;

   int n_checks = 0;
   int n_fail   = 0;

   logic [16:0] sb_q[$];   // {addr, data}

   typedef struct {
      int         sample;
      int         hold;
      bit         wr;
      logic [8:0] addr;
      logic [7:0] data;
   } vec_t;

   vec_t vecs[9];

   wave_capture_ctrl #(.SAMPLE_W(16), .TIMEOUT(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .new_sample_ready (new_sample_ready),
      .new_sample_in    (new_sample_in),
      .wave_display_idle(wave_display_idle),
      .write_address    (write_address),
      .write_enable     (write_enable),
      .write_sample     (write_sample),
      .read_index       (read_index),
      .forced_trigger   (forced_trigger)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every observed write must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && write_enable) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%h data=%h, none expected",
                     write_address, write_sample);
         end else begin
            logic [16:0] e;
            e = sb_q.pop_front();
            if ({write_address, write_sample} !== e) begin
               n_fail++;
               $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                        write_address, write_sample, e[16:8], e[7:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input int s, input int hold);
      @(negedge clk);
      new_sample_in    = 16'(s);
      new_sample_ready = 1'b1;
      repeat (hold) @(negedge clk);
      new_sample_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic expect_write(input logic [8:0] addr, input logic [7:0] data);
      sb_q.push_back({addr, data});
   endtask

   // Every expected write must have been seen within a few cycles.
   task automatic drain(input string name);
      repeat (4) @(negedge clk);
      check(name, sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic run_table(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (vecs[i].wr) expect_write(vecs[i].addr, vecs[i].data);
         send(vecs[i].sample, vecs[i].hold);
      end
   endtask

   // Feed samples for capture positions first..first+count-1 of the half 'upper'.
   task automatic feed_capture(input int first, input int count, input bit upper);
      for (int i = 0; i < count; i++) begin
         int s;
         int p;
         p = first + i;
         s = (p % 2 == 1) ? -(p * 97) : p * 113;
         expect_write({upper, 8'(p)}, 8'(128 + (s >>> 8)));
         send(s, 1);
      end
   endtask

   task automatic idle_pulse();
      @(negedge clk);
      wave_display_idle = 1'b1;
      @(negedge clk);
      wave_display_idle = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_we"},     write_enable,   0);
      check({tag, "_addr"},   write_address,  0);
      check({tag, "_data"},   write_sample,   0);
      check({tag, "_ri"},     read_index,     0);
      check({tag, "_forced"}, forced_trigger, 0);
   endtask

   initial begin
      vecs[0] = '{-5,     1, 1'b0, 9'h000, 8'h00};
      vecs[1] = '{-1,     1, 1'b0, 9'h000, 8'h00};
      vecs[2] = '{0,      1, 1'b1, 9'h100, 8'h80};
      vecs[3] = '{7,      1, 1'b1, 9'h101, 8'h80};
      vecs[4] = '{9,      1, 1'b0, 9'h000, 8'h00};
      vecs[5] = '{-2,     1, 1'b0, 9'h000, 8'h00};
      vecs[6] = '{4,      1, 1'b1, 9'h100, 8'h80};
      vecs[7] = '{32767,  5, 1'b1, 9'h101, 8'hFF};
      vecs[8] = '{-32768, 5, 1'b1, 9'h102, 8'h00};

      reset             = 1'b0;
      new_sample_ready  = 1'b0;
      new_sample_in     = '0;
      wave_display_idle = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      reset = 1'b1;

      // Trigger on rising crossing: -5, -1, 0, 7
      run_table(0, 3);
      check("trig_forced", forced_trigger, 0);

      // Full capture into upper half, then WAIT ignores samples
      feed_capture(2, 254, 1'b1);
      send(-3, 1);
      send(5, 1);
      send(-40, 1);
      send(60, 1);
      drain("capture1_drain");
      check("wait_ri", read_index, 0);

      // Flip in WAIT
      idle_pulse();
      #1;
      check("flip_ri", read_index, 1);

      // Capture into lower half, with idle pulses during ACTIVE
      send(-10, 1);
      expect_write(9'h000, 8'h80);
      send(20, 1);
      idle_pulse();
      feed_capture(1, 100, 1'b0);
      idle_pulse();
      check("active_idle_ri", read_index, 1);
      feed_capture(101, 155, 1'b0);
      send(50, 1);   // ignored in WAIT, leaves prev sample non-negative
      drain("capture2_drain");
      check("wait2_ri", read_index, 1);
      idle_pulse();
      #1;
      check("flip2_ri", read_index, 0);

      // Forced trigger: constant +100, 16th sample written
      for (int k = 1; k <= 15; k++) send(100, 1);
      drain("timeout_nowrite");
      check("timeout_pre_forced", forced_trigger, 0);
      expect_write(9'h100, 8'h80);
      send(100, 1);
      drain("timeout_write");
      check("timeout_forced", forced_trigger, 1);
      feed_capture(1, 255, 1'b1);
      drain("capture3_drain");
      idle_pulse();
      #1;
      check("flip3_ri", read_index, 1);
      check("forced_hold", forced_trigger, 1);
      send(-1, 1);
      expect_write(9'h000, 8'h80);
      send(3, 1);
      drain("real_trig_drain");
      check("real_trig_forced", forced_trigger, 0);

      // Reset mid-capture
      feed_capture(1, 2, 1'b0);
      drain("pre_reset_drain");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_zero_outputs("midreset");
      @(negedge clk);
      reset = 1'b1;

      // First sample after reset cannot trigger; next capture uses upper half.
      // Held strobe gives exactly one write each; full-scale conversion.
      run_table(4, 8);
      drain("final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
